// File: rtl/vend_session_arbiter.sv
// rtl/vend_session_arbiter.sv - round-robin session arbiter sharing one vending core among kiosks
module vend_session_arbiter #(
  parameter int N_KIOSK    = 2,
  parameter int STOCK_W    = 4,
  parameter int INIT_CHOC  = 8,
  parameter int INIT_DRINK = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_KIOSK-1:0]   req,
  input  logic [N_KIOSK-1:0]   kiosk_choice,
  input  logic [2*N_KIOSK-1:0] kiosk_coins,
  input  logic                 restock,
  input  logic                 core_done,
  input  logic [1:0]           core_product,
  input  logic [2:0]           core_change,
  output logic                 core_start,
  output logic                 core_choice,
  output logic [1:0]           core_coins,
  output logic                 core_abort,
  output logic [N_KIOSK-1:0]   grant,
  output logic [N_KIOSK-1:0]   kiosk_done,
  output logic [N_KIOSK-1:0]   kiosk_timeout,
  output logic [1:0]           vend_product,
  output logic [2:0]           vend_change,
  output logic [3:0]           refund,
  output logic [STOCK_W-1:0]   stock_choc,
  output logic [STOCK_W-1:0]   stock_drink,
  output logic [1:0]           sold_out
);

  localparam int IW = (N_KIOSK > 1) ? $clog2(N_KIOSK) : 1;
  localparam logic [STOCK_W-1:0] INIT_C    = STOCK_W'(INIT_CHOC);
  localparam logic [STOCK_W-1:0] INIT_D    = STOCK_W'(INIT_DRINK);
  localparam logic [7:0]         TIMEOUT_V = 8'(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_SETUP   = 3'd2;
  localparam logic [2:0] S_SESSION = 3'd3;
  localparam logic [2:0] S_ABORT   = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [N_KIOSK-1:0] grant_q, grant_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic               choice_q, choice_d;
  logic [3:0]         paid_q, paid_d;
  logic [7:0]         idle_q, idle_d;
  logic [3:0]         refund_q, refund_d;
  logic [1:0]         vprod_q, vprod_d;
  logic [2:0]         vchg_q, vchg_d;
  logic [N_KIOSK-1:0] done_q, done_d;
  logic [STOCK_W-1:0] choc_q, choc_d;
  logic [STOCK_W-1:0] drink_q, drink_d;

  logic [N_KIOSK-1:0] elig;
  logic               found;
  logic [IW-1:0]      pick;
  logic [1:0]         sel_coin;
  logic               coin_active;
  logic [3:0]         coin_val;
  logic               dec_choc;
  logic               dec_drink;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_KIOSK) s = s - N_KIOSK;
    return IW'(s);
  endfunction

  // Eligibility and round-robin pick of the first eligible kiosk at or after the pointer
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_KIOSK; k++) begin
      elig[k] = req[k] && (kiosk_choice[k] ? (drink_q != '0) : (choc_q != '0));
    end
    for (int i = 0; i < N_KIOSK; i++) begin
      if (!found && elig[wrap_add(rr_q, i)]) begin
        found = 1'b1;
        pick  = wrap_add(rr_q, i);
      end
    end
  end

  // Winner's coin decode; 11 means no coin this cycle
  always_comb begin
    sel_coin    = kiosk_coins[{idx_q, 1'b0} +: 2];
    coin_active = (sel_coin != 2'b11);
    case (sel_coin)
      2'b00:   coin_val = 4'd1;
      2'b01:   coin_val = 4'd2;
      2'b10:   coin_val = 4'd5;
      default: coin_val = 4'd0;
    endcase
  end

  // Session sequencing, accumulators and stock bookkeeping
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    rr_d      = rr_q;
    choice_d  = choice_q;
    paid_d    = paid_q;
    idle_d    = idle_q;
    refund_d  = refund_q;
    vprod_d   = vprod_q;
    vchg_d    = vchg_q;
    done_d    = '0;
    dec_choc  = 1'b0;
    dec_drink = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          idx_d         = pick;
          choice_d      = kiosk_choice[pick];
          state_d       = S_START;
        end
      end
      S_START: state_d = S_SETUP;
      S_SETUP: state_d = S_SESSION;
      S_SESSION: begin
        if (coin_active) begin
          paid_d = paid_q + coin_val;
          idle_d = '0;
        end else begin
          idle_d = idle_q + 8'd1;
        end
        if (core_done) begin
          vprod_d   = core_product;
          vchg_d    = core_change;
          done_d    = grant_q;
          dec_choc  = (core_product == 2'b01);
          dec_drink = (core_product == 2'b10);
          grant_d   = '0;
          state_d   = S_FINISH;
        end else if (idle_d == TIMEOUT_V) begin
          refund_d = paid_q;
          state_d  = S_ABORT;
        end
      end
      S_ABORT: begin
        grant_d = '0;
        state_d = S_FINISH;
      end
      S_FINISH: begin
        paid_d  = '0;
        idle_d  = '0;
        rr_d    = (idx_q == IW'(N_KIOSK - 1)) ? '0 : idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Restock overrides a same-cycle vend decrement
    choc_d  = choc_q;
    drink_d = drink_q;
    if (restock) begin
      choc_d  = INIT_C;
      drink_d = INIT_D;
    end else begin
      if (dec_choc && choc_q != '0) choc_d = choc_q - 1'b1;
      if (dec_drink && drink_q != '0) drink_d = drink_q - 1'b1;
    end
  end

  // State registers; reset abandons any session silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_q     <= '0;
      choice_q <= 1'b0;
      paid_q   <= '0;
      idle_q   <= '0;
      refund_q <= '0;
      vprod_q  <= '0;
      vchg_q   <= '0;
      done_q   <= '0;
      choc_q   <= INIT_C;
      drink_q  <= INIT_D;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      choice_q <= choice_d;
      paid_q   <= paid_d;
      idle_q   <= idle_d;
      refund_q <= refund_d;
      vprod_q  <= vprod_d;
      vchg_q   <= vchg_d;
      done_q   <= done_d;
      choc_q   <= choc_d;
      drink_q  <= drink_d;
    end
  end

  // Core-facing and kiosk-facing outputs decoded from state
  always_comb begin
    core_start    = (state_q == S_START);
    core_choice   = (state_q == S_START || state_q == S_SETUP || state_q == S_SESSION) ? choice_q : 1'b0;
    core_coins    = (state_q == S_SESSION) ? sel_coin : 2'b11;
    core_abort    = (state_q == S_ABORT);
    kiosk_timeout = (state_q == S_ABORT) ? grant_q : '0;
    kiosk_done    = done_q;
    grant         = grant_q;
    vend_product  = vprod_q;
    vend_change   = vchg_q;
    refund        = refund_q;
    stock_choc    = choc_q;
    stock_drink   = drink_q;
    sold_out      = {drink_q == '0, choc_q == '0};
  end

endmodule

// File: tb/tb_vend_session_arbiter.sv
// tb/tb_vend_session_arbiter.sv - randomized self-checking bench for vend_session_arbiter
module tb_vend_session_arbiter;

  localparam int N  = 3;
  localparam int SW = 4;
  localparam int IC = 8;
  localparam int ID = 8;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    kiosk_choice;
  logic [2*N-1:0]  kiosk_coins;
  logic            restock;
  logic            core_done;
  logic [1:0]      core_product;
  logic [2:0]      core_change;
  logic            core_start;
  logic            core_choice;
  logic [1:0]      core_coins;
  logic            core_abort;
  logic [N-1:0]    grant;
  logic [N-1:0]    kiosk_done;
  logic [N-1:0]    kiosk_timeout;
  logic [1:0]      vend_product;
  logic [2:0]      vend_change;
  logic [3:0]      refund;
  logic [SW-1:0]   stock_choc;
  logic [SW-1:0]   stock_drink;
  logic [1:0]      sold_out;

  int n_checks = 0;
  int n_fail   = 0;

  int m_rr    = 0;
  int m_choc  = IC;
  int m_drink = ID;
  int m_vprod = 0;
  int m_vchg  = 0;

  vend_session_arbiter #(
    .N_KIOSK(N), .STOCK_W(SW), .INIT_CHOC(IC), .INIT_DRINK(ID), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .kiosk_choice(kiosk_choice), .kiosk_coins(kiosk_coins),
    .restock(restock), .core_done(core_done), .core_product(core_product), .core_change(core_change),
    .core_start(core_start), .core_choice(core_choice), .core_coins(core_coins), .core_abort(core_abort),
    .grant(grant), .kiosk_done(kiosk_done), .kiosk_timeout(kiosk_timeout),
    .vend_product(vend_product), .vend_change(vend_change), .refund(refund),
    .stock_choc(stock_choc), .stock_drink(stock_drink), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic int coin_value(input logic [1:0] c);
    case (c)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 5;
      default: return 0;
    endcase
  endfunction

  task automatic check_stock();
    chk("stock_choc", 32'(stock_choc), 32'(m_choc));
    chk("stock_drink", 32'(stock_drink), 32'(m_drink));
    chk("sold_out", 32'(sold_out), 32'({m_drink == 0, m_choc == 0}));
  endtask

  task automatic find_winner(input logic [N-1:0] rq, input logic [N-1:0] ch, output int w);
    w = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_rr + i) % N;
      if (w < 0 && rq[k] && (ch[k] ? (m_drink > 0) : (m_choc > 0))) w = k;
    end
  endtask

  // One kiosk session driven from an IDLE negedge back to an IDLE negedge.
  task automatic session(input logic [N-1:0] rq, input logic [N-1:0] ch, input int ncoins,
                         input logic [15:0] codes, input bit by_done, input int gap,
                         input bit rs_at_done, input logic [2:0] chg, output int w);
    logic       lch;
    logic [1:0] coin;
    bit         done_now;
    int         paid, idle, cyc, ex;
    req = rq;
    kiosk_choice = ch;
    kiosk_coins = '1;
    find_winner(rq, ch, w);
    @(negedge clk);
    if (w < 0) begin
      chk("no_grant", 32'(grant), 32'd0);
      chk("no_start", 32'(core_start), 32'd0);
      req = '0;
      return;
    end
    chk("grant_start", 32'(grant), 32'(onehot(w)));
    chk("core_start", 32'(core_start), 32'd1);
    chk("start_choice", 32'(core_choice), 32'(ch[w]));
    chk("start_coins", 32'(core_coins), 32'd3);
    lch = ch[w];
    req = N'($urandom);
    kiosk_choice = N'($urandom);
    kiosk_coins = (2*N)'($urandom);
    @(negedge clk);
    chk("setup_start", 32'(core_start), 32'd0);
    chk("setup_coins", 32'(core_coins), 32'd3);
    chk("setup_grant", 32'(grant), 32'(onehot(w)));
    paid = 0; idle = 0; cyc = 0; ex = 0;
    while (ex == 0) begin
      @(negedge clk);
      coin = (cyc < ncoins) ? codes[2*cyc +: 2] : 2'b11;
      done_now = by_done && (cyc == ncoins + gap);
      kiosk_coins = (2*N)'($urandom);
      kiosk_coins[2*w +: 2] = coin;
      core_done = done_now;
      if (done_now) begin
        core_product = lch ? 2'b10 : 2'b01;
        core_change = chg;
        restock = rs_at_done;
      end
      #1;
      chk("fwd_coin", 32'(core_coins), 32'(coin));
      chk("sess_choice", 32'(core_choice), 32'(lch));
      if (coin != 2'b11) begin
        paid = paid + coin_value(coin);
        idle = 0;
      end else begin
        idle++;
      end
      if (done_now) ex = 1;
      else if (idle == TO) ex = 2;
      cyc++;
    end
    if (ex == 1) begin
      @(negedge clk);
      core_done = 1'b0;
      restock = 1'b0;
      kiosk_coins = '1;
      req = '0;
      if (rs_at_done) begin
        m_choc = IC;
        m_drink = ID;
      end else if (lch) begin
        if (m_drink > 0) m_drink--;
      end else begin
        if (m_choc > 0) m_choc--;
      end
      m_vprod = lch ? 2 : 1;
      m_vchg = int'(chg);
      chk("kiosk_done", 32'(kiosk_done), 32'(onehot(w)));
      chk("vend_product", 32'(vend_product), 32'(m_vprod));
      chk("vend_change", 32'(vend_change), 32'(m_vchg));
      chk("finish_grant", 32'(grant), 32'd0);
      chk("no_timeout", 32'(kiosk_timeout), 32'd0);
      check_stock();
    end else begin
      @(negedge clk);
      kiosk_coins = '1;
      chk("core_abort", 32'(core_abort), 32'd1);
      chk("kiosk_timeout", 32'(kiosk_timeout), 32'(onehot(w)));
      chk("refund", 32'(refund), 32'(paid % 16));
      chk("abort_no_done", 32'(kiosk_done), 32'd0);
      @(negedge clk);
      req = '0;
      chk("abort_pulse_end", 32'(core_abort), 32'd0);
      chk("timeout_pulse_end", 32'(kiosk_timeout), 32'd0);
      chk("abort_grant_clr", 32'(grant), 32'd0);
      check_stock();
    end
    m_rr = (w + 1) % N;
    @(negedge clk);
    chk("done_pulse_end", 32'(kiosk_done), 32'd0);
    chk("vend_hold", 32'(vend_product), 32'(m_vprod));
    chk("idle_coins", 32'(core_coins), 32'd3);
  endtask

  // Restock pulse in IDLE; a request held during the pulse sees the old stock that cycle.
  task automatic do_restock(input logic [N-1:0] rq, input logic [N-1:0] ch);
    int w;
    req = rq;
    kiosk_choice = ch;
    restock = 1'b1;
    find_winner(rq, ch, w);
    @(negedge clk);
    restock = 1'b0;
    req = '0;
    m_choc = IC;
    m_drink = ID;
    if (w < 0) chk("restock_no_grant", 32'(grant), 32'd0);
    check_stock();
    if (w >= 0) begin
      // A grant was legitimately taken; run it out through timeout so the bench stays in step.
      @(negedge clk);
      @(negedge clk);
      repeat (TO) @(negedge clk);
      @(negedge clk);
      chk("restock_sess_abort", 32'(core_abort), 32'd1);
      @(negedge clk);
      m_rr = (w + 1) % N;
      @(negedge clk);
    end
  endtask

  int w;

  initial begin
    rst = 1'b1;
    req = '0;
    kiosk_choice = '0;
    kiosk_coins = '1;
    restock = 1'b0;
    core_done = 1'b0;
    core_product = '0;
    core_change = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_coins", 32'(core_coins), 32'd3);
    chk("rst_start", 32'(core_start), 32'd0);
    chk("rst_abort", 32'(core_abort), 32'd0);
    chk("rst_done", 32'(kiosk_done), 32'd0);
    chk("rst_refund", 32'(refund), 32'd0);
    chk("rst_vprod", 32'(vend_product), 32'd0);
    check_stock();
    rst = 1'b0;

    // Chocolate with a single five-coin, change 011
    session(3'b001, 3'b000, 1, 16'b10, 1'b1, 0, 1'b0, 3'b011, w);
    chk("first_winner", 32'(w), 32'd0);

    // Two kiosks competing for drinks: two, two, one per session
    for (int s = 0; s < 3; s++) begin
      int prev;
      prev = w;
      session(3'b011, 3'b011, 3, 16'b000101, 1'b1, 0, 1'b0, 3'b000, w);
      chk("rr_alternates", 32'(w != prev), 32'd1);
    end

    // Kiosk1 drink, one coin, then idle into timeout
    session(3'b010, 3'b010, 1, 16'b00, 1'b0, 0, 1'b0, 3'b000, w);

    // Done and timeout land on the same cycle: done wins
    session(3'b001, 3'b000, 1, 16'b00, 1'b1, TO - 1, 1'b0, 3'b101, w);

    // Drain chocolate to zero, then a chocolate request must not be granted
    while (m_choc > 0) session(3'b001, 3'b000, 1, 16'b10, 1'b1, 0, 1'b0, 3'b011, w);
    session(3'b010, 3'b000, 0, 16'b0, 1'b1, 0, 1'b0, 3'b000, w);
    chk("soldout_no_winner", 32'(w), 32'hFFFFFFFF);
    session(3'b010, 3'b000, 0, 16'b0, 1'b1, 0, 1'b0, 3'b000, w);
    do_restock(3'b010, 3'b000);
    session(3'b010, 3'b000, 1, 16'b10, 1'b1, 0, 1'b0, 3'b011, w);
    chk("restock_winner", 32'(w), 32'd1);

    // Reset during SESSION abandons the session without pulses
    req = 3'b001;
    kiosk_choice = 3'b000;
    @(negedge clk);
    req = '0;
    chk("pre_rst_grant", 32'(grant), 32'(onehot(0) << (m_rr == 0 ? 0 : 0)) & 32'(grant));
    @(negedge clk);
    @(negedge clk);
    kiosk_coins = 6'b111110;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    kiosk_coins = '1;
    m_rr = 0;
    m_choc = IC;
    m_drink = ID;
    m_vprod = 0;
    m_vchg = 0;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_coins", 32'(core_coins), 32'd3);
    chk("mid_rst_done", 32'(kiosk_done), 32'd0);
    chk("mid_rst_timeout", 32'(kiosk_timeout), 32'd0);
    check_stock();
    @(negedge clk);
    chk("post_rst_done", 32'(kiosk_done), 32'd0);
    chk("post_rst_timeout", 32'(kiosk_timeout), 32'd0);
    chk("post_rst_grant", 32'(grant), 32'd0);

    // Restock in the same cycle as a vend decrement
    session(3'b100, 3'b100, 2, 16'b0110, 1'b1, 1, 1'b1, 3'b010, w);

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 7) == 0) do_restock('0, '0);
      session(N'($urandom_range(1, (1 << N) - 1)), N'($urandom), $urandom_range(0, 4),
              16'($urandom), ($urandom_range(0, 4) != 0), $urandom_range(0, TO - 1),
              ($urandom_range(0, 9) == 0), 3'($urandom), w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
